// File: rtl/alu4_arb.sv
// rtl/alu4_arb.sv - two-port round-robin arbiter feeding one alu4 with a one-entry result buffer
// alu4 is the shared 4-bit datapath; alu4_arb owns arbitration, buffering and grant counters.

module alu4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] opt,
  output logic [3:0] y
);

  always_comb begin
    y = 4'h0;
    case (opt)
      3'b000: y = a + b;
      3'b001: y = a - b;
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = {3'b000, (a < b)};
      3'b110: y = {3'b000, ($signed(a) < $signed(b))};
      3'b111: y = {3'b000, (a == b)};
      default: y = 4'h0;
    endcase
  end

endmodule

module alu4_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_opt,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_opt,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_y,
  output logic       res_src,
  output logic [7:0] gnt_cnt0,
  output logic [7:0] gnt_cnt1
);

  logic       free;
  logic       last;
  logic       gnt0;
  logic       gnt1;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opt;
  logic [3:0] alu_y;

  // last = 1 means port 1 won most recently, so port 0 wins the next contention
  assign free = !res_valid || res_ready;
  assign gnt0 = free && req0_valid && (!req1_valid || last);
  assign gnt1 = free && req1_valid && (!req0_valid || !last);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign alu_a   = gnt1 ? req1_a   : req0_a;
  assign alu_b   = gnt1 ? req1_b   : req0_b;
  assign alu_opt = gnt1 ? req1_opt : req0_opt;

  alu4 u_alu4 (
    .a   (alu_a),
    .b   (alu_b),
    .opt (alu_opt),
    .y   (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_y     <= 4'h0;
      res_src   <= 1'b0;
      last      <= 1'b1;
      gnt_cnt0  <= 8'h00;
      gnt_cnt1  <= 8'h00;
    end else if (gnt0 || gnt1) begin
      res_valid <= 1'b1;
      res_y     <= alu_y;
      res_src   <= gnt1;
      last      <= gnt1;
      if (gnt0) gnt_cnt0 <= gnt_cnt0 + 8'h01;
      if (gnt1) gnt_cnt1 <= gnt_cnt1 + 8'h01;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu4_arb.sv
// tb/tb_alu4_arb.sv - randomized and directed self-checking bench for alu4_arb
// A transaction-level model of the buffer, pointer and counters predicts every output.

module tb_alu4_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = 4'h0, req0_b = 4'h0, req1_a = 4'h0, req1_b = 4'h0;
  logic [2:0] req0_opt = 3'b000, req1_opt = 3'b000;
  logic       res_valid, res_src;
  logic       res_ready = 1'b0;
  logic [3:0] res_y;
  logic [7:0] gnt_cnt0, gnt_cnt1;

  alu4_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_opt   (req0_opt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_opt   (req1_opt),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_y      (res_y),
    .res_src    (res_src),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model state
  int m_valid, m_y, m_src, m_last, m_cnt0, m_cnt1;
  int last_g;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int to_signed4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic int alu_ref(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % 16;
      6: return (to_signed4(a) < to_signed4(b)) ? 1 : 0;
      7: return (a == b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int pick_op();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? 0 : (r == 1) ? 6 : 7;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_y = 0; m_src = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, res_valid, m_valid);
    check({tag, "_y"}, res_y, m_y);
    check({tag, "_src"}, res_src, m_src);
    check({tag, "_cnt0"}, gnt_cnt0, m_cnt0);
    check({tag, "_cnt1"}, gnt_cnt1, m_cnt1);
  endtask

  // One clock: called just after a falling edge, returns just after the next falling edge.
  task automatic step(input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] o0,
                      input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] o1,
                      input logic rr);
    int  g;
    bit  free;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_opt = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_opt = o1;
    res_ready = rr;
    #1;
    free = (m_valid == 0) || rr;
    if (rst || !free) g = -1;
    else if (v0 && v1) g = 1 - m_last;
    else if (v0) g = 0;
    else if (v1) g = 1;
    else g = -1;
    if (!rst) begin
      check("ready0", req0_ready, (g == 0) ? 1 : 0);
      check("ready1", req1_ready, (g == 1) ? 1 : 0);
    end
    @(posedge clk);
    if (rst) model_reset();
    else if (g == 0) begin
      m_y = alu_ref(a0, b0, o0); m_src = 0; m_valid = 1; m_last = 0; m_cnt0 = (m_cnt0 + 1) % 256;
    end else if (g == 1) begin
      m_y = alu_ref(a1, b1, o1); m_src = 1; m_valid = 1; m_last = 1; m_cnt1 = (m_cnt1 + 1) % 256;
    end else if (rr) m_valid = 0;
    last_g = g;
    #1;
    check_outputs("out");
    @(negedge clk);
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  logic       p0v, p1v;
  logic [3:0] p0a, p0b, p1a, p1b;
  logic [2:0] p0o, p1o;
  int         held_y, held_src;

  initial begin
    model_reset();
    @(negedge clk);
    reset_cycle();
    check("rst_valid", res_valid, 0);
    check("rst_cnt0", gnt_cnt0, 0);

    // single port add
    step(1, 4'd3, 4'd4, 3'b000, 0, 0, 0, 0, 1);
    check("single_y", res_y, 7);
    check("single_cnt0", gnt_cnt0, 1);

    // signed compare sweep on port 1
    reset_cycle();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        step(0, 0, 0, 0, 1, a[3:0], b[3:0], 3'b110, 1);
        check("sweep_ok", last_g, 1);
      end
    check("sweep_wrap", gnt_cnt1, 0);

    // contention alternates from port 0 after reset
    reset_cycle();
    for (int i = 0; i < 8; i++) begin
      step(1, 4'(i), 4'd1, 3'b000, 1, 4'(i), 4'(i), 3'b111, 1);
      check("cont_src", res_src, i % 2);
    end
    check("cont_cnt0", gnt_cnt0, 4);
    check("cont_cnt1", gnt_cnt1, 4);

    // back-pressure: buffered result held for 3 cycles with both ports waiting
    step(1, 4'd9, 4'd5, 3'b000, 0, 0, 0, 0, 1);
    held_y = res_y;
    held_src = res_src;
    for (int i = 0; i < 3; i++) begin
      step(1, 4'd2, 4'd2, 3'b111, 1, 4'd7, 4'd8, 3'b000, 0);
      check("stall_y", res_y, held_y);
      check("stall_src", res_src, held_src);
    end
    step(1, 4'd2, 4'd2, 3'b111, 1, 4'd7, 4'd8, 3'b000, 1);
    check("drain_load_valid", res_valid, 1);

    // mid-operation reset, then first contention goes to port 0
    reset_cycle();
    check("midrst_valid", res_valid, 0);
    check("midrst_cnt1", gnt_cnt1, 0);
    step(1, 4'd1, 4'd1, 3'b000, 1, 4'd2, 4'd2, 3'b000, 1);
    check("midrst_first", res_src, 0);

    // idle drain
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("idle_valid", res_valid, 0);

    // randomized traffic with held requests and random back-pressure
    p0v = 0; p1v = 0;
    p0a = 0; p0b = 0; p0o = 0; p1a = 0; p1b = 0; p1o = 0;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        reset_cycle();
      end
      if (!p0v) begin
        p0v = 1'($urandom_range(0, 1));
        p0a = 4'($urandom); p0b = 4'($urandom); p0o = 3'(pick_op());
      end
      if (!p1v) begin
        p1v = 1'($urandom_range(0, 1));
        p1a = 4'($urandom); p1b = 4'($urandom); p1o = 3'(pick_op());
      end
      step(p0v, p0a, p0b, p0o, p1v, p1a, p1b, p1o, ($urandom_range(0, 3) != 0));
      if (last_g == 0) p0v = 0;
      if (last_g == 1) p1v = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu4_arb.md
# alu4_arb

Two-port round-robin arbiter and result buffer for the shared `alu4` datapath. Requester 0 and requester 1 each present a 4-bit operand pair and a 3-bit opcode through a valid/ready handshake. The block grants one request per cycle to the single `alu4` instance. It registers the 4-bit result, tagged with the source port, into a one-entry output buffer drained by a valid/ready consumer. Per-port 8-bit grant counters are provided for debug.

## Interface
- No parameters; all widths are fixed by `alu4` (4-bit operands, 3-bit opcode).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  port 0 has a request.
- `req0_ready`  out  1  port 0 request accepted this cycle.
- `req0_a`, `req0_b`  in  4  port 0 operands (two's complement where the opcode is signed).
- `req0_opt`  in  3  port 0 opcode, passed unmodified to `alu4.opt`.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_opt`: same as port 0, for port 1.
- `res_valid`  out  1  output buffer holds a result.
- `res_ready`  in  1  consumer takes the result this cycle.
- `res_y`  out  4  buffered `alu4.y`.
- `res_src`  out  1  port that produced `res_y` (0 or 1).
- `gnt_cnt0`, `gnt_cnt1`  out  8  accepted-request counts per port; wrap 255→0.

## Operation
- One `alu4` instance. Its inputs are muxed from the granted port. When no port is granted, the mux selects port 0; `alu4` output is then ignored.
- `free = !res_valid || res_ready`: the buffer is empty, or it is being drained this cycle.
- Arbitration happens only when `free`. Otherwise both `reqN_ready` = 0.
  - Only one port valid: grant that port.
  - Both ports valid: grant the port not granted last (`last` register).
  - Neither port valid: no grant.
- `reqN_ready` = 1 only for the granted port. It is a combinational function of `req*_valid`, `res_valid`, `res_ready` and `last`.
- Accept (`reqN_valid && reqN_ready`) updates on the next edge:
  - `res_y` <= `alu4.y`;
  - `res_src` <= N;
  - `res_valid` <= 1;
  - `last` <= N;
  - `gnt_cntN` <= `gnt_cntN` + 1 (mod 256).
- Drain without accept (`res_valid && res_ready`, no grant): `res_valid` <= 0. `res_y` and `res_src` hold their stale values.
- Drain and accept in the same cycle: the new result replaces the old one with no bubble, and `res_valid` stays 1.
- Stall (`res_valid && !res_ready`): `res_y`, `res_src` and `res_valid` hold. No grants are made; the requests wait and the `last` pointer is unchanged.
- Opcode semantics are owned by `alu4`. The encodings used in this spec's tests are 000 add (mod 16), 110 signed less-than (y = 0001 if a<b, else 0000) and 111 equal.
- Requesters must hold `a`, `b`, `opt` stable while `valid` is high and `ready` is low. The block does not check this.

## Timing
- Reset values: `res_valid` = 0, `res_y` = 0, `res_src` = 0, `last` = 1 (port 0 wins the first contention), `gnt_cnt0` = `gnt_cnt1` = 0. With `res_valid` = 0, `req*_ready` follows the arbitration rule immediately after reset.
- Latency: a request accepted in cycle N has its result visible in cycle N+1 (`res_valid` = 1).
- Throughput: one result per cycle while `res_ready` is held at 1.
- Under continuous contention with `res_ready` = 1, grants alternate 0,1,0,1… starting with port 0 after reset.
- Reset asserted mid-operation: the buffered result is discarded on that edge. `res_valid` = 0 and the reset values above are restored. During the reset cycle, `req*_ready` is a don't-care and no accept is counted.
- No combinational path from `req*_a`, `req*_b`, `req*_opt` to any output other than through registered `res_y`.

## Test plan
- Single port: port 0 presents a=3, b=4, opt=000 with `res_ready` = 1. `req0_ready` = 1 in cycle 0; the next cycle shows `res_valid` = 1, `res_y` = 7, `res_src` = 0 and `gnt_cnt0` = 1.
- Signed compare sweep: port 1 only, opt=110, all a,b in -8..7 (256 requests back-to-back, `res_ready` = 1).
  - Each result equals (a<b signed) ? 0001 : 0000, e.g. a=4'hD (-3), b=2 → 1.
  - One result per cycle; `gnt_cnt1` wraps to 0 after the 256th accept.
- Contention: both ports valid every cycle with `res_ready` = 1 → `res_src` sequence is 0,1,0,1… for 8 results, and `gnt_cnt0` = `gnt_cnt1` = 4.
- Back-pressure: `res_ready` = 0 for 3 cycles with a result buffered and both ports valid.
  - During the stall: `req*_ready` = 0 and `res_y`/`res_src` are stable.
  - When `res_ready` = 1: the stalled result drains and a new one is loaded the same cycle, with `res_valid` staying 1.
- Mid-operation reset: `rst` = 1 for one cycle while `res_valid` = 1 → the next cycle shows `res_valid` = 0 and both counters = 0. Then, with both ports valid, the first grant goes to port 0.
- Idle drain: one result buffered, no requests, `res_ready` = 1 → `res_valid` falls next cycle and the counters are unchanged.
